// File: rtl/jtag_host.sv
// JTAG host: walks a TAP from Run-Test/Idle through reset, IR or DR scans,
// driving TCK/TMS/TDI at a divided rate and collecting TDO bits LSB first.
module jtag_host #(
    parameter int MAX_BITS = 32,
    parameter int LEN_W    = 6,
    parameter int CLK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic [MAX_BITS-1:0] cmd_tdi,
    output logic                rsp_valid,
    output logic [MAX_BITS-1:0] rsp_tdo,
    output logic                busy,
    output logic                tck,
    output logic                tms,
    output logic                tdi,
    input  logic                tdo
);
    localparam int DIV_W = $clog2(2 * CLK_DIV);
    localparam int IDX_W = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
    localparam logic [LEN_W-1:0] MAX_L  = LEN_W'(MAX_BITS);
    localparam logic [LEN_W-1:0] ZERO_L = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] ONE_L  = LEN_W'(1);
    localparam logic [DIV_W-1:0] ZERO_D = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] ONE_D  = DIV_W'(1);
    localparam logic [DIV_W-1:0] RISE_D = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] LAST_D = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [1:0] OP_RST = 2'd0;
    localparam logic [1:0] OP_IR  = 2'd1;
    localparam logic [1:0] OP_DR  = 2'd2;

    typedef enum logic [2:0] {IDLE, PRE, SHIFT, POST, DONE} state_t;

    state_t              state_r, state_s;
    logic [LEN_W-1:0]    cnt_r, cnt_s;
    logic [DIV_W-1:0]    div_r, div_s;
    logic [1:0]          op_r, op_s;
    logic [LEN_W-1:0]    len_r, len_s;
    logic [MAX_BITS-1:0] data_r, data_s;
    logic [MAX_BITS-1:0] rsp_r, rsp_s;
    logic                tck_r, tck_s;
    logic                tms_r, tms_s;
    logic                tdi_r, tdi_s;
    logic [3:0]          pre_pat_s;
    logic [1:0]          pre_last_s;

    // Header TMS pattern (LSB = first period). TAP reset borrows the 1,0
    // trailer, so four leading ones plus the trailer give 1,1,1,1,1,0.
    always_comb begin
        case (op_r)
            OP_RST: begin pre_pat_s = 4'b1111; pre_last_s = 2'd3; end
            OP_IR:  begin pre_pat_s = 4'b0011; pre_last_s = 2'd3; end
            default: begin pre_pat_s = 4'b0001; pre_last_s = 2'd2; end
        endcase
    end

    // Next-state, TCK phase, TMS/TDI and TDO capture logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        div_s   = div_r;
        op_s    = op_r;
        len_s   = len_r;
        data_s  = data_r;
        rsp_s   = rsp_r;
        tck_s   = tck_r;
        tms_s   = tms_r;
        tdi_s   = tdi_r;
        case (state_r)
            IDLE, DONE: begin
                tck_s = 1'b0;
                if (cmd_valid) begin
                    op_s   = cmd_op;
                    len_s  = (cmd_len > MAX_L) ? MAX_L : cmd_len;
                    data_s = cmd_tdi;
                    rsp_s  = {MAX_BITS{1'b0}};
                    div_s  = ZERO_D;
                    cnt_s  = ZERO_L;
                    tdi_s  = 1'b0;
                    if ((cmd_op == OP_RST) ||
                        (((cmd_op == OP_IR) || (cmd_op == OP_DR)) && (cmd_len != ZERO_L))) begin
                        state_s = PRE;
                        tms_s   = 1'b1;
                    end else begin
                        state_s = DONE;
                        tms_s   = 1'b0;
                    end
                end else if (state_r == DONE) begin
                    state_s = IDLE;
                end else begin
                    state_s = IDLE;
                end
            end
            PRE, SHIFT, POST: begin
                div_s = div_r + ONE_D;
                if (div_r == RISE_D) begin
                    tck_s = 1'b1;
                    if (state_r == SHIFT) begin
                        rsp_s[cnt_r[IDX_W-1:0]] = tdo;
                    end else begin
                        rsp_s = rsp_r;
                    end
                end else if (div_r == LAST_D) begin
                    div_s = ZERO_D;
                    tck_s = 1'b0;
                    tdi_s = 1'b0;
                    case (state_r)
                        PRE: begin
                            if (cnt_r == LEN_W'(pre_last_s)) begin
                                cnt_s   = ZERO_L;
                                state_s = (op_r == OP_RST) ? POST : SHIFT;
                            end else begin
                                cnt_s = cnt_r + ONE_L;
                            end
                        end
                        SHIFT: begin
                            if (cnt_r == (len_r - ONE_L)) begin
                                cnt_s   = ZERO_L;
                                state_s = POST;
                            end else begin
                                cnt_s = cnt_r + ONE_L;
                            end
                        end
                        default: begin
                            if (cnt_r == ONE_L) begin
                                state_s = DONE;
                            end else begin
                                cnt_s = cnt_r + ONE_L;
                            end
                        end
                    endcase
                    case (state_s)
                        PRE:   tms_s = pre_pat_s[cnt_s[1:0]];
                        SHIFT: begin
                            tms_s = (cnt_s == (len_r - ONE_L));
                            tdi_s = data_r[cnt_s[IDX_W-1:0]];
                        end
                        POST:  tms_s = (cnt_s == ZERO_L);
                        default: tms_s = 1'b0;
                    endcase
                end else begin
                    tck_s = tck_r;
                end
            end
            default: begin
                state_s = IDLE;
                tck_s   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= ZERO_L;
            div_r   <= ZERO_D;
            op_r    <= 2'd0;
            len_r   <= ZERO_L;
            data_r  <= {MAX_BITS{1'b0}};
            rsp_r   <= {MAX_BITS{1'b0}};
            tck_r   <= 1'b0;
            tms_r   <= 1'b1;
            tdi_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            div_r   <= div_s;
            op_r    <= op_s;
            len_r   <= len_s;
            data_r  <= data_s;
            rsp_r   <= rsp_s;
            tck_r   <= tck_s;
            tms_r   <= tms_s;
            tdi_r   <= tdi_s;
        end
    end

    assign cmd_ready = (state_r == IDLE) || (state_r == DONE);
    assign busy      = !cmd_ready;
    assign rsp_valid = (state_r == DONE);
    assign rsp_tdo   = rsp_r;
    assign tck       = tck_r;
    assign tms       = tms_r;
    assign tdi       = tdi_r;
endmodule
